caliptra_tlul_socket_m1_rr: RTL and testbench



---
 rtl/caliptra_tlul_pkg.sv | 44 ++++
 rtl/caliptra_tlul_socket_m1_rr.sv | 161 ++++++++++++++++
 tb/tb_caliptra_tlul_socket_m1_rr.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/caliptra_tlul_pkg.sv
// TL-UL channel types shared by the socket and its bench.
// Ports: none (package). Fixed 32-bit address/data, 8-bit source, 1-bit sink.
// The a_user/d_user integrity fields ride along untouched through the socket.
package caliptra_tlul_pkg;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/caliptra_tlul_socket_m1_rr.sv
// TL-UL M:1 socket: round-robin merge of M hosts onto one device, host index tagged in a_source low bits.
// Latency: 0 cycles on both a and d channels (purely combinational paths, no buffering).
// Backpressure: a stalled grant is locked until accepted; hosts at MaxOutstanding are not arbitrated.
// Ports: clk_i/rst_i (sync, active-high), tl_h_i/tl_h_o host side [M], tl_d_o/tl_d_i device side,
//        err_unroutable_o (pulse after a response with tag >= M is dropped), idle_o.
module caliptra_tlul_socket_m1_rr
  import caliptra_tlul_pkg::*;
#(
  parameter int unsigned M              = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h_i [M],
  output tl_d2h_t tl_h_o [M],
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    err_unroutable_o,
  output logic    idle_o
);

  localparam int unsigned IDW = $clog2(M);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]     state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] grant_q;
  logic [3:0]     cnt_q [M];
  logic           err_q;

  logic [M-1:0]   elig;
  logic [2*M-1:0] elig_rot;
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] grant;
  logic           gnt_vld;
  logic           a_acc;
  logic [IDW-1:0] tag;
  logic           tag_ok;
  logic           rsp_rdy;
  logic           rsp_acc;

  // (base + off) mod M without a divider; base < M and off < M keep the sum below 2M.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    logic [IDW:0] s;
    s = {1'b0, base} + (IDW+1)'(off);
    if (s >= (IDW+1)'(M)) s = s - (IDW+1)'(M);
    return s[IDW-1:0];
  endfunction

  // Rotating the doubled request vector by rr_ptr turns the wrapped scan into a plain first-one search.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      elig[i] = !rst_i && tl_h_i[i].a_valid && (cnt_q[i] < 4'(MaxOutstanding));
    end
    elig_rot = {elig, elig} >> rr_ptr_q;
    found    = 1'b0;
    pick     = rr_ptr_q;
    for (int k = 0; k < M; k++) begin
      if (!found && elig_rot[k]) begin
        found = 1'b1;
        pick  = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // While locked the held host is presented unconditionally so the device sees a stable request.
  assign grant   = (state_q == StLocked) ? grant_q : pick;
  assign gnt_vld = !rst_i && ((state_q == StLocked) ? tl_h_i[grant_q].a_valid : found);
  assign a_acc   = gnt_vld && tl_d_i.a_ready;

  assign tag    = tl_d_i.d_source[IDW-1:0];
  assign tag_ok = ({1'b0, tag} < (IDW+1)'(M));

  // Unroutable responses are sunk so a bad tag can never wedge the device's d channel.
  always_comb begin
    rsp_rdy = 1'b1;
    if (tag_ok) begin
      for (int i = 0; i < M; i++) begin
        if (tag == IDW'(i)) rsp_rdy = tl_h_i[i].d_ready;
      end
    end
  end
  assign rsp_acc = tl_d_i.d_valid && rsp_rdy;

  always_comb begin
    tl_d_o          = tl_h_i[grant];
    tl_d_o.a_valid  = gnt_vld;
    tl_d_o.a_source = {tl_h_i[grant].a_source[7-IDW:0], grant};
    tl_d_o.d_ready  = rsp_rdy;
  end

  always_comb begin
    for (int i = 0; i < M; i++) begin
      tl_h_o[i]          = tl_d_i;
      tl_h_o[i].d_valid  = tl_d_i.d_valid && tag_ok && (tag == IDW'(i));
      tl_h_o[i].d_source = tl_d_i.d_source >> IDW;
      tl_h_o[i].a_ready  = a_acc && (grant == IDW'(i));
    end
  end

  always_comb begin
    idle_o = (state_q == StIdle);
    for (int i = 0; i < M; i++) begin
      if (cnt_q[i] != 4'd0) idle_o = 1'b0;
    end
    idle_o = idle_o || rst_i;
  end

  assign err_unroutable_o = err_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < M; i++) cnt_q[i] <= 4'd0;
    end else begin
      err_q <= tl_d_i.d_valid && !tag_ok;

      case (state_q)
        StIdle: begin
          if (found) begin
            if (tl_d_i.a_ready) begin
              rr_ptr_q <= wrap_add(pick, 1);
            end else begin
              grant_q <= pick;
              state_q <= StLocked;
            end
          end
        end
        default: begin
          if (a_acc) begin
            rr_ptr_q <= wrap_add(grant_q, 1);
            state_q  <= StIdle;
          end
        end
      endcase

      // A response for a host already at 0 (orphaned by a reset) must not wrap the counter.
      for (int i = 0; i < M; i++) begin
        logic inc;
        logic dec;
        inc = a_acc && (grant == IDW'(i));
        dec = rsp_acc && tag_ok && (tag == IDW'(i)) && (cnt_q[i] != 4'd0);
        if (inc && !dec)      cnt_q[i] <= cnt_q[i] + 4'd1;
        else if (dec && !inc) cnt_q[i] <= cnt_q[i] - 4'd1;
      end
    end
  end

  // The top IDW source bits are overwritten by the host tag, so hosts must leave them clear.
  for (genvar gi = 0; gi < M; gi++) begin : g_src_chk
    a_src_fits : assert property (@(posedge clk_i) disable iff (rst_i)
      tl_h_i[gi].a_valid |-> (tl_h_i[gi].a_source[7:8-IDW] == '0));
  end

endmodule

// File: tb/tb_caliptra_tlul_socket_m1_rr.sv
// Bench for caliptra_tlul_socket_m1_rr (M=3, MaxOutstanding=4): directed steps with request/response scoreboards.
// Inputs change 1 time unit after the rising edge; combinational checks follow 1 unit later; monitors sample on the falling edge.
module tb_caliptra_tlul_socket_m1_rr;
  import caliptra_tlul_pkg::*;

  localparam int M = 3;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  tl_h2d_t h_in  [M];
  tl_d2h_t h_out [M];
  tl_h2d_t d_out;
  tl_d2h_t d_in;
  logic    err;
  logic    idle;

  int checks   = 0;
  int failures = 0;

  typedef struct { int host; logic [7:0] src; } req_exp_t;
  typedef struct { int host; logic [7:0] src; logic [31:0] data; } rsp_exp_t;
  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  caliptra_tlul_socket_m1_rr #(.M(3), .MaxOutstanding(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .tl_h_i           (h_in),
    .tl_h_o           (h_out),
    .tl_d_o           (d_out),
    .tl_d_i           (d_in),
    .err_unroutable_o (err),
    .idle_o           (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Device-side source is the host's source shifted up by the 2-bit host index.
  task automatic push_req(input int host, input logic [7:0] src);
    req_exp_t e;
    e.host = host;
    e.src  = {src[5:0], 2'b00} | 8'(host);
    req_q.push_back(e);
  endtask

  task automatic push_rsp(input int host, input logic [7:0] src, input logic [31:0] data);
    rsp_exp_t e;
    e.host = host;
    e.src  = src;
    e.data = data;
    rsp_q.push_back(e);
  endtask

  function automatic logic [2:0] a_rdy_vec();
    logic [2:0] v;
    for (int i = 0; i < M; i++) v[i] = h_out[i].a_ready;
    return v;
  endfunction

  function automatic logic [2:0] d_vld_vec();
    logic [2:0] v;
    for (int i = 0; i < M; i++) v[i] = h_out[i].d_valid;
    return v;
  endfunction

  // Request monitor: every device-side acceptance must match the next expected grant.
  always @(negedge clk) begin
    if (!rst && d_out.a_valid && d_in.a_ready) begin
      req_exp_t e;
      chk("req_expected", 64'(req_q.size() > 0), 64'(1));
      if (req_q.size() > 0) begin
        e = req_q.pop_front();
        chk("req_src", 64'(d_out.a_source), 64'(e.src));
        chk("req_host_rdy", 64'(a_rdy_vec()), 64'(3'b001 << e.host));
      end
    end
  end

  // Response monitor: every host-side handshake must match the next expected response.
  always @(negedge clk) begin
    for (int i = 0; i < M; i++) begin
      if (!rst && h_out[i].d_valid && h_in[i].d_ready) begin
        rsp_exp_t e;
        chk("rsp_expected", 64'(rsp_q.size() > 0), 64'(1));
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          chk("rsp_host", 64'(i), 64'(e.host));
          chk("rsp_src", 64'(h_out[i].d_source), 64'(e.src));
          chk("rsp_data", 64'(h_out[i].d_data), 64'(e.data));
        end
      end
    end
  end

  task automatic do_reset();
    chk("q_empty_before_reset", 64'(req_q.size() + rsp_q.size()), 64'(0));
    for (int i = 0; i < M; i++) begin
      h_in[i]         = '0;
      h_in[i].d_ready = 1'b1;
    end
    d_in = '0;
    rst  = 1'b1;
    cyc();
    rst  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < M; i++) begin
      h_in[i]         = '0;
      h_in[i].d_ready = 1'b1;
    end
    d_in = '0;

    // Reset: a request presented during reset must not reach the device.
    rst             = 1'b1;
    h_in[0].a_valid = 1'b1;
    d_in.a_ready    = 1'b1;
    cyc();
    cyc();
    settle();
    chk("rst_a_valid", 64'(d_out.a_valid), 64'(0));
    chk("rst_a_ready", 64'(a_rdy_vec()), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_err", 64'(err), 64'(0));

    // Round robin with all hosts requesting and the device always ready.
    cyc();
    rst = 1'b0;
    for (int i = 0; i < M; i++) begin
      h_in[i].a_valid  = 1'b1;
      h_in[i].a_source = 8'(i + 1);
    end
    for (int n = 0; n < 6; n++) push_req(n % 3, 8'((n % 3) + 1));
    for (int n = 0; n < 6; n++) begin
      settle();
      chk("rr_tag", 64'(d_out.a_source[1:0]), 64'(n % 3));
      cyc();
    end
    for (int i = 0; i < M; i++) h_in[i].a_valid = 1'b0;
    settle();
    chk("rr_not_idle", 64'(idle), 64'(0));

    // Lock: host 1 stalls for three cycles while host 0 also asks.
    do_reset();
    d_in.a_ready           = 1'b0;
    h_in[1].a_valid        = 1'b1;
    h_in[1].a_source       = 8'h05;
    h_in[1].a_user.cmd_intg = 7'h5A;
    settle();
    chk("lock_src_c1", 64'(d_out.a_source), 64'(8'h15));
    chk("lock_user_pass", 64'(d_out.a_user.cmd_intg), 64'(7'h5A));
    chk("lock_rdy_c1", 64'(a_rdy_vec()), 64'(0));
    cyc();
    h_in[0].a_valid  = 1'b1;
    h_in[0].a_source = 8'h07;
    settle();
    chk("lock_src_c2", 64'(d_out.a_source), 64'(8'h15));
    chk("lock_rdy_c2", 64'(a_rdy_vec()), 64'(0));
    cyc();
    settle();
    chk("lock_src_c3", 64'(d_out.a_source), 64'(8'h15));
    cyc();
    d_in.a_ready = 1'b1;
    push_req(1, 8'h05);
    settle();
    chk("lock_rdy_c4", 64'(a_rdy_vec()), 64'(3'b010));
    cyc();
    h_in[1].a_valid = 1'b0;
    push_req(0, 8'h07);
    settle();
    chk("lock_next_src", 64'(d_out.a_source), 64'(8'h1C));
    cyc();
    h_in[0].a_valid = 1'b0;

    // Response routing to host 2; d_ready tracks host 2.
    d_in.d_valid    = 1'b1;
    d_in.d_opcode   = 3'h1;
    d_in.d_source   = 8'h16;
    d_in.d_data     = 32'hDEADBEEF;
    h_in[2].d_ready = 1'b0;
    settle();
    chk("rsp_dready_0", 64'(d_out.d_ready), 64'(0));
    chk("rsp_dvalid_vec", 64'(d_vld_vec()), 64'(3'b100));
    chk("rsp_h2_src", 64'(h_out[2].d_source), 64'(8'h05));
    chk("rsp_h2_data", 64'(h_out[2].d_data), 64'(32'hDEADBEEF));
    chk("rsp_h2_opcode", 64'(h_out[2].d_opcode), 64'(3'h1));
    h_in[2].d_ready = 1'b1;
    push_rsp(2, 8'h05, 32'hDEADBEEF);
    settle();
    chk("rsp_dready_1", 64'(d_out.d_ready), 64'(1));
    cyc();
    d_in.d_valid = 1'b0;

    // Outstanding limit on host 0, then release by a response.
    do_reset();
    h_in[0].a_valid  = 1'b1;
    h_in[0].a_source = 8'h02;
    d_in.a_ready     = 1'b1;
    for (int n = 0; n < 4; n++) push_req(0, 8'h02);
    for (int n = 0; n < 4; n++) begin
      settle();
      chk("max_h0_rdy", 64'(h_out[0].a_ready), 64'(1));
      cyc();
    end
    h_in[1].a_valid  = 1'b1;
    h_in[1].a_source = 8'h03;
    push_req(1, 8'h03);
    settle();
    chk("max_h0_blocked", 64'(h_out[0].a_ready), 64'(0));
    chk("max_h1_tag", 64'(d_out.a_source[1:0]), 64'(1));
    cyc();
    h_in[1].a_valid = 1'b0;
    settle();
    chk("max_no_req", 64'(d_out.a_valid), 64'(0));
    d_in.d_valid  = 1'b1;
    d_in.d_source = 8'h08;
    d_in.d_data   = 32'h11112222;
    push_rsp(0, 8'h02, 32'h11112222);
    settle();
    chk("max_still_blocked", 64'(d_out.a_valid), 64'(0));
    cyc();
    // Accept and response for host 0 in the same cycle leave its count at 3.
    d_in.d_data = 32'h33334444;
    push_rsp(0, 8'h02, 32'h33334444);
    push_req(0, 8'h02);
    settle();
    chk("max_release_rdy", 64'(h_out[0].a_ready), 64'(1));
    cyc();
    d_in.d_valid = 1'b0;
    push_req(0, 8'h02);
    settle();
    chk("max_same_cycle_rdy", 64'(h_out[0].a_ready), 64'(1));
    cyc();
    settle();
    chk("max_blocked_again", 64'(d_out.a_valid), 64'(0));
    h_in[0].a_valid = 1'b0;

    // Unroutable response tag 3.
    d_in.d_valid  = 1'b1;
    d_in.d_source = 8'h13;
    for (int i = 0; i < M; i++) h_in[i].d_ready = 1'b0;
    settle();
    chk("unr_dready", 64'(d_out.d_ready), 64'(1));
    chk("unr_dvalid_vec", 64'(d_vld_vec()), 64'(0));
    chk("unr_err_pre", 64'(err), 64'(0));
    cyc();
    d_in.d_valid = 1'b0;
    for (int i = 0; i < M; i++) h_in[i].d_ready = 1'b1;
    settle();
    chk("unr_err_pulse", 64'(err), 64'(1));
    cyc();
    h_in[0].a_valid = 1'b1;
    settle();
    chk("unr_err_clear", 64'(err), 64'(0));
    chk("unr_cnt_kept", 64'(d_out.a_valid), 64'(0));
    h_in[0].a_valid = 1'b0;

    // Reset while locked with two outstanding on host 0.
    do_reset();
    h_in[0].a_valid  = 1'b1;
    h_in[0].a_source = 8'h01;
    d_in.a_ready     = 1'b1;
    push_req(0, 8'h01);
    push_req(0, 8'h01);
    cyc();
    cyc();
    d_in.a_ready = 1'b0;
    settle();
    chk("rl_grant0", 64'(d_out.a_source[1:0]), 64'(0));
    cyc();
    h_in[1].a_valid  = 1'b1;
    h_in[1].a_source = 8'h04;
    settle();
    chk("rl_locked", 64'(d_out.a_source[1:0]), 64'(0));
    rst = 1'b1;
    cyc();
    settle();
    chk("rl_a_valid", 64'(d_out.a_valid), 64'(0));
    chk("rl_idle_rst", 64'(idle), 64'(1));
    chk("rl_a_ready", 64'(a_rdy_vec()), 64'(0));
    rst = 1'b0;
    settle();
    chk("rl_idle_after", 64'(idle), 64'(1));
    chk("rl_restart_h0", 64'(d_out.a_source[1:0]), 64'(0));
    d_in.a_ready = 1'b1;
    push_req(0, 8'h01);
    cyc();
    push_req(1, 8'h04);
    settle();
    chk("rl_next_h1", 64'(d_out.a_source[1:0]), 64'(1));
    cyc();
    h_in[0].a_valid = 1'b0;
    h_in[1].a_valid = 1'b0;
    cyc();
    cyc();
    chk("req_q_drained", 64'(req_q.size()), 64'(0));
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
